// File: rtl/vsync_frame_switch.sv
// vsync_frame_switch: frame-aligned video channel switcher.
// Accepts a switch request for a target channel and a frame budget, moves
// o_ch_sel to the target only on a vsync rising edge, counts frames shown on
// it, and returns to the home channel at a frame boundary when the budget is
// spent or the operation is aborted.
// Optional build macro: VSW_VSYNC_SYNC_EN adds a 2-flop synchroniser in front
// of the vsync edge detector, for a vsync that is asynchronous to i_ddr_clk.
module vsync_frame_switch #(
  parameter int CH_NUM     = 4,
  parameter int SEL_W      = 2,
  parameter int CNT_W      = 8,
  parameter int DEFAULT_CH = 0
) (
  input  logic             i_ddr_clk,
  input  logic             i_rst_n,
  input  logic             i_sel_vsync,
  input  logic             i_req,
  input  logic [SEL_W-1:0] i_req_ch,
  input  logic [CNT_W-1:0] i_req_frames,
  input  logic             i_abort,
  output logic [SEL_W-1:0] o_ch_sel,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [CNT_W-1:0] o_frame_cnt
);

  localparam logic [SEL_W-1:0] HOME_CH = SEL_W'(DEFAULT_CH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2,
    RETURN = 2'd3
  } state_t;

  state_t           state;
  logic [SEL_W-1:0] ch_reg;
  logic [CNT_W-1:0] frames_reg;
  logic             abort_pending;

  logic             vs_src;
  logic             d0;
  logic             d1;
  logic             vs_pos;
  logic             req_ok;
  logic             terminal;

`ifdef VSW_VSYNC_SYNC_EN
  // fill tracks how many pipeline stages hold a genuinely sampled value
  localparam int FILL_W = 4;
  logic meta0;
  logic meta1;

  // Two-flop synchroniser for an asynchronous vsync
  always_ff @(posedge i_ddr_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta0 <= 1'b0;
      meta1 <= 1'b0;
    end else begin
      meta0 <= i_sel_vsync;
      meta1 <= meta0;
    end
  end

  assign vs_src = meta1;
`else
  localparam int FILL_W = 2;
  assign vs_src = i_sel_vsync;
`endif

  logic [FILL_W-1:0] fill;

  // Edge-detect pipeline; fill masks edges until d1 holds a real sample so a
  // vsync already high at reset release is not mistaken for a fresh rise
  always_ff @(posedge i_ddr_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      d0   <= 1'b0;
      d1   <= 1'b0;
      fill <= '0;
    end else begin
      d0   <= vs_src;
      d1   <= d0;
      fill <= {fill[FILL_W-2:0], 1'b1};
    end
  end

  assign vs_pos   = d0 & ~d1 & fill[FILL_W-1];
  assign req_ok   = ({{(32-SEL_W){1'b0}}, i_req_ch} < 32'(CH_NUM));
  assign terminal = (frames_reg != '0) && (o_frame_cnt == (frames_reg - CNT_W'(1)));

  // Switch controller: state, latched request and all registered outputs
  always_ff @(posedge i_ddr_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      o_ch_sel      <= HOME_CH;
      o_frame_cnt   <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
      ch_reg        <= '0;
      frames_reg    <= '0;
      abort_pending <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (state)
        IDLE: begin
          // busy stays high through the o_done cycle, then drops here
          o_busy <= 1'b0;
          if (i_req) begin
            if (req_ok) begin
              ch_reg     <= i_req_ch;
              frames_reg <= i_req_frames;
              o_busy     <= 1'b1;
              state      <= ARMED;
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        ARMED: begin
          if (i_abort) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end else if (vs_pos) begin
            o_ch_sel    <= ch_reg;
            o_frame_cnt <= '0;
            state       <= ACTIVE;
          end
        end
        ACTIVE: begin
          // an abort landing on a frame boundary returns right away
          if (vs_pos && (i_abort || terminal)) begin
            o_ch_sel      <= HOME_CH;
            o_done        <= 1'b1;
            abort_pending <= 1'b0;
            state         <= IDLE;
          end else if (i_abort) begin
            abort_pending <= 1'b1;
            state         <= RETURN;
          end else if (vs_pos && (o_frame_cnt != CNT_MAX)) begin
            o_frame_cnt <= o_frame_cnt + CNT_W'(1);
          end
        end
        RETURN: begin
          if (vs_pos && abort_pending) begin
            o_ch_sel      <= HOME_CH;
            o_done        <= 1'b1;
            abort_pending <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vsync_frame_switch.sv
// Self-checking bench for vsync_frame_switch (CH_NUM=4, select widened to
// 3 bits so out-of-range channels can be requested). A monitor compares
// o_ch_sel changes, o_done and o_err pulses against expected-event queues.
module tb_vsync_frame_switch;

  localparam int CH_NUM     = 4;
  localparam int SEL_W      = 3;
  localparam int CNT_W      = 8;
  localparam int DEFAULT_CH = 0;
`ifdef VSW_VSYNC_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             vsync;
  logic             req;
  logic [SEL_W-1:0] req_ch;
  logic [CNT_W-1:0] req_frames;
  logic             abort;
  logic [SEL_W-1:0] ch_sel;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] frame_cnt;

  always #5 clk = ~clk;

  vsync_frame_switch #(
    .CH_NUM(CH_NUM), .SEL_W(SEL_W), .CNT_W(CNT_W), .DEFAULT_CH(DEFAULT_CH)
  ) dut (
    .i_ddr_clk(clk), .i_rst_n(rst_n), .i_sel_vsync(vsync), .i_req(req),
    .i_req_ch(req_ch), .i_req_frames(req_frames), .i_abort(abort),
    .o_ch_sel(ch_sel), .o_busy(busy), .o_done(done), .o_err(err),
    .o_frame_cnt(frame_cnt)
  );

  typedef struct {
    int               cyc;
    logic [SEL_W-1:0] ch;
  } sel_ev_t;

  typedef struct {
    logic [SEL_W-1:0] ch;
    logic [CNT_W-1:0] frames;
    logic             exp_err;
    logic             exp_busy;
  } vec_t;

  sel_ev_t          sel_q[$];
  int               done_q[$];
  int               err_q[$];
  int               cyc = 0;
  int               total = 0;
  int               passed = 0;
  logic [SEL_W-1:0] prev_sel = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: sample 1 time unit after each edge, stimulus changes at +2
  always @(posedge clk) begin
    sel_ev_t ev;
    int      exp_cyc;
    #1;
    cyc++;
    if (!rst_n) begin
      prev_sel = ch_sel;
    end else begin
      if (ch_sel !== prev_sel) begin
        if (sel_q.size() == 0) begin
          check("sel_unexpected_change", 32'(ch_sel), 32'(prev_sel));
        end else begin
          ev = sel_q.pop_front();
          check("sel_change_cycle", 32'(cyc), 32'(ev.cyc));
          check("sel_change_value", 32'(ch_sel), 32'(ev.ch));
        end
        prev_sel = ch_sel;
      end
      if (done === 1'b1) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", 32'(done), 32'(0));
        end else begin
          exp_cyc = done_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(exp_cyc));
          check("busy_during_done", 32'(busy), 32'(1));
        end
      end
      if (err === 1'b1) begin
        if (err_q.size() == 0) begin
          check("err_unexpected", 32'(err), 32'(0));
        end else begin
          exp_cyc = err_q.pop_front();
          check("err_cycle", 32'(cyc), 32'(exp_cyc));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_req(input logic [SEL_W-1:0] ch, input logic [CNT_W-1:0] fr);
    req = 1'b1; req_ch = ch; req_frames = fr;
    tick(1);
    req = 1'b0;
  endtask

  // One vsync frame; optionally expect a select change and/or done pulse
  task automatic vs_rise(input int high, input int low, input bit sw,
                         input logic [SEL_W-1:0] ch, input bit dn);
    sel_ev_t ev;
    if (sw) begin
      ev.cyc = cyc + LAT; ev.ch = ch;
      sel_q.push_back(ev);
    end
    if (dn) done_q.push_back(cyc + LAT);
    vsync = 1'b1;
    tick(high);
    vsync = 1'b0;
    tick(low);
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t    tbl[6];
    sel_ev_t ev;

    rst_n = 1'b0; vsync = 1'b0; req = 1'b0; req_ch = '0; req_frames = '0; abort = 1'b0;

    tbl[0] = '{ch: 3'd5, frames: 8'd3, exp_err: 1'b1, exp_busy: 1'b0};
    tbl[1] = '{ch: 3'd4, frames: 8'd1, exp_err: 1'b1, exp_busy: 1'b0};
    tbl[2] = '{ch: 3'd7, frames: 8'd0, exp_err: 1'b1, exp_busy: 1'b0};
    tbl[3] = '{ch: 3'd3, frames: 8'd2, exp_err: 1'b0, exp_busy: 1'b1};
    tbl[4] = '{ch: 3'd0, frames: 8'd1, exp_err: 1'b0, exp_busy: 1'b1};
    tbl[5] = '{ch: 3'd2, frames: 8'd0, exp_err: 1'b0, exp_busy: 1'b1};

    // Reset state
    tick(3);
    check("rst_sel", 32'(ch_sel), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_cnt", 32'(frame_cnt), 32'(0));
    rst_n = 1'b1;
    tick(3);
    check("rst_done", 32'(done), 32'(0));
    check("rst_err", 32'(err), 32'(0));

    // Request decode table: accept/reject, then abort from ARMED/IDLE
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].exp_err) err_q.push_back(cyc + 1);
      do_req(tbl[i].ch, tbl[i].frames);
      check($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
      check($sformatf("tbl%0d_sel", i), 32'(ch_sel), 32'(0));
      pulse_abort();
      check($sformatf("tbl%0d_busy_after", i), 32'(busy), 32'(0));
      check($sformatf("tbl%0d_err_after", i), 32'(err), 32'(0));
      tick(2);
    end

    // ch=2, 3 frames, 100-cycle vsync period
    do_req(3'd2, 8'd3);
    check("a_busy_armed", 32'(busy), 32'(1));
    vs_rise(10, 90, 1'b1, 3'd2, 1'b0);
    check("a_sel_r1", 32'(ch_sel), 32'(2));
    check("a_cnt_r1", 32'(frame_cnt), 32'(0));
    vs_rise(10, 90, 1'b0, 3'd0, 1'b0);
    check("a_cnt_r2", 32'(frame_cnt), 32'(1));
    vs_rise(10, 90, 1'b0, 3'd0, 1'b0);
    check("a_cnt_r3", 32'(frame_cnt), 32'(2));
    check("a_sel_r3", 32'(ch_sel), 32'(2));
    vs_rise(10, 90, 1'b1, 3'd0, 1'b1);
    check("a_sel_end", 32'(ch_sel), 32'(0));
    check("a_busy_end", 32'(busy), 32'(0));

    // ch=1 held indefinitely, abort after 5 frames
    do_req(3'd1, 8'd0);
    vs_rise(10, 40, 1'b1, 3'd1, 1'b0);
    for (int r = 0; r < 5; r++) vs_rise(10, 40, 1'b0, 3'd0, 1'b0);
    check("b_cnt_abort", 32'(frame_cnt), 32'(5));
    pulse_abort();
    tick(20);
    check("b_sel_hold", 32'(ch_sel), 32'(1));
    check("b_busy_hold", 32'(busy), 32'(1));
    vs_rise(10, 40, 1'b1, 3'd0, 1'b1);
    check("b_busy_end", 32'(busy), 32'(0));

    // Request coincident with vs_pos, then abort while ARMED
    vsync = 1'b1;
    tick(LAT - 1);
    do_req(3'd3, 8'd1);
    check("c_busy_accept", 32'(busy), 32'(1));
    pulse_abort();
    check("c_busy_abort", 32'(busy), 32'(0));
    tick(10);
    vsync = 1'b0;
    tick(20);
    vs_rise(5, 15, 1'b0, 3'd0, 1'b0);
    check("c_sel", 32'(ch_sel), 32'(0));

    // Request coincident with vs_pos: switch waits for the next rise; frames=1
    vsync = 1'b1;
    tick(LAT - 1);
    do_req(3'd3, 8'd1);
    tick(5);
    vsync = 1'b0;
    tick(15);
    check("c2_sel_wait", 32'(ch_sel), 32'(0));
    check("c2_busy_wait", 32'(busy), 32'(1));
    vs_rise(5, 15, 1'b1, 3'd3, 1'b0);
    vs_rise(5, 15, 1'b1, 3'd0, 1'b1);
    check("c2_busy_end", 32'(busy), 32'(0));

    // Abort coinciding with the terminating vs_pos: single return
    do_req(3'd2, 8'd2);
    vs_rise(5, 15, 1'b1, 3'd2, 1'b0);
    vs_rise(5, 15, 1'b0, 3'd0, 1'b0);
    check("t_cnt", 32'(frame_cnt), 32'(1));
    ev.cyc = cyc + LAT; ev.ch = 3'd0;
    sel_q.push_back(ev);
    done_q.push_back(cyc + LAT);
    vsync = 1'b1;
    tick(LAT - 1);
    pulse_abort();
    tick(5);
    vsync = 1'b0;
    tick(15);
    vs_rise(5, 15, 1'b0, 3'd0, 1'b0);
    vs_rise(5, 15, 1'b0, 3'd0, 1'b0);
    check("t_busy_end", 32'(busy), 32'(0));

    // Reset while ACTIVE on ch=3; vsync high across release
    do_req(3'd3, 8'd0);
    vs_rise(5, 20, 1'b1, 3'd3, 1'b0);
    rst_n = 1'b0;
    #1;
    check("d_sel_rst", 32'(ch_sel), 32'(0));
    check("d_busy_rst", 32'(busy), 32'(0));
    check("d_cnt_rst", 32'(frame_cnt), 32'(0));
    vsync = 1'b1;
    tick(3);
    rst_n = 1'b1;
    do_req(3'd2, 8'd2);
    check("d_busy_new", 32'(busy), 32'(1));
    tick(8);
    check("d_no_stale_edge", 32'(ch_sel), 32'(0));
    vsync = 1'b0;
    tick(10);
    vs_rise(5, 15, 1'b1, 3'd2, 1'b0);
    vs_rise(5, 15, 1'b0, 3'd0, 1'b0);
    vs_rise(5, 15, 1'b1, 3'd0, 1'b1);
    check("d_busy_end", 32'(busy), 32'(0));

    // Frame counter saturation
    do_req(3'd1, 8'd0);
    vs_rise(2, 2, 1'b1, 3'd1, 1'b0);
    for (int r = 0; r < 257; r++) vs_rise(2, 2, 1'b0, 3'd0, 1'b0);
    check("e_cnt_sat", 32'(frame_cnt), 32'(255));
    pulse_abort();
    vs_rise(2, 8, 1'b1, 3'd0, 1'b1);
    check("e_busy_end", 32'(busy), 32'(0));

    tick(5);
    while (sel_q.size() > 0) begin
      ev = sel_q.pop_front();
      check("sel_missing", 32'(0), 32'(ev.cyc));
    end
    while (done_q.size() > 0) check("done_missing", 32'(0), 32'(done_q.pop_front()));
    while (err_q.size() > 0) check("err_missing", 32'(0), 32'(err_q.pop_front()));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
